rv_ctrl_pipe: RTL
=================

Name: rv_ctrl_pipe

Overview:
Parametrised, registered successor to the combinational RV32I control sub-decoder. It decodes the full 32-bit instruction word into the datapath control bundle and buffers decoded entries in a small FIFO with valid/ready handshakes on both sides. It resolves branches at the FIFO head from comparator flags and self-flushes younger entries on a taken branch or jump. It sits between fetch and the execute/writeback datapath, with optional RV64 load/store modes.

Parameters:
XLEN, 32, datapath width; 32 or 64. 64 enables LD/LWU/SD.
DEPTH, 2, decoded-entry FIFO depth; power of two, 2..8.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction word present
in_ready  out  1  FIFO can accept
instr  in  32  instruction word
flush_in  in  1  external kill of all buffered and incoming entries
out_valid  out  1  head entry valid
out_ready  in  1  execute consumes head
br_eq  in  1  comparator equal for head operands, sampled when out_valid
br_lt  in  1  comparator less-than, signedness per br_un
br_un  out  1  head branch is unsigned (funct3[1])
pc_sel  out  1  1 = next PC from ALU, 0 = PC+4
reg_wen  out  1  register file write enable
a_sel  out  1  1 = PC, 0 = rs1 data
b_sel  out  1  1 = immediate, 0 = rs2 data
data_w_sel  out  2  store mode: 00 word, 01 byte, 11 half, 10 double
mem_rw  out  1  1 = write, 0 = read
data_r_sel  out  3  load mode: 000 word, 001 byte, 010 half, 011 ubyte, 100 uhalf, 101 uword, 110 double
wb_sel  out  2  00 memory, 01 ALU, 10 PC+4
illegal  out  1  head entry is an undecodable instruction

Behaviour:
- Decode is combinational on instr[6:0] and instr[14:12]. Opcodes: R 0110011, I_C 0010011, I_L 0000011, S 0100011, B 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111. The decoded bundle is written into the FIFO on an input fire (in_valid & in_ready).
- Bundle rules:
  - reg_wen = ~(S|B|illegal).
  - a_sel = B|AUIPC|JAL.
  - b_sel = ~R.
  - mem_rw = S & ~illegal.
  - wb_sel = 00 for I_L, 10 for JAL/JALR, else 01.
  - data_w_sel / data_r_sel as encoded above; 00 / 000 when not S / I_L.
- Illegal encodings:
  - Unknown opcode.
  - B funct3 010/011.
  - I_L funct3 111; 011 and 110 when XLEN=32.
  - S funct3 1xx; 011 when XLEN=32.
  - JALR funct3 != 000.
  - An illegal entry forces reg_wen=0, mem_rw=0 and pc_sel=0.
- Latency: at least one cycle. An instruction accepted in cycle N is at the head in cycle N+1 if the FIFO was empty.
- in_ready = (count < DEPTH). out_valid = (count > 0). Simultaneous push and pop when full is not allowed, because in_ready=0.
- Head outputs are combinational from the head entry and are zero whenever out_valid=0.
- pc_sel = out_valid & ~illegal & (JAL|JALR | B&taken), where:
  - funct3 00x: taken = br_eq ^ f[0].
  - funct3 1xx: taken = br_lt ^ f[0].
- Redirect: on a head pop (out_valid & out_ready) with pc_sel=1:
  - All other buffered entries are discarded and count goes to 0.
  - A same-cycle input fire is dropped: in_ready still reads 1, but the entry is not written.
- flush_in (synchronous): count goes to 0 next cycle and same-cycle input is dropped. It takes priority over push, pop and redirect.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.
- Reset (async assert, sync deassert by the environment):
  - count, read pointer and write pointer go to 0, so out_valid=0 and all bundle outputs read 0.
  - in_ready=1 immediately.
  - Reset asserted mid-operation discards all entries without a pop.

Test Plan:
- Reset, then push 0x0000a103 (lw x2,0(x1)) -> next cycle out_valid=1, reg_wen=1, b_sel=1, data_r_sel=000, wb_sel=00, mem_rw=0, illegal=0.
- Head 0x00208463 (beq) with br_eq=1 -> pc_sel=1, reg_wen=0, a_sel=1. With br_eq=0 -> pc_sel=0. A bne variant with br_eq=0 -> pc_sel=1.
- Hold out_ready=0 and push DEPTH words -> in_ready=0 after DEPTH fires. One pop -> in_ready=1. Order is preserved and the pointers wrap.
- Push jal 0x0080006f followed by 0x00000013 and 0x00208023, then pop jal with pc_sel=1 while a new word is offered -> count=0 next cycle and the new word is absent.
- XLEN=32: 0x0000b103 (ld) -> illegal=1, reg_wen=0, pc_sel=0. XLEN=64: same word -> data_r_sel=110, illegal=0.
- Assert flush_in with the FIFO full, and rst_n low mid-stream -> out_valid=0 in the following cycle (immediately for rst_n) and all outputs are 0.

Source files
------------

// File: rtl/rv_ctrl_pipe.sv
// Registered RV32I/RV64 control decoder: decodes the instruction word into the datapath
// control bundle, buffers it in a small FIFO and resolves branches/jumps at the head.
module rv_ctrl_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic        flush_in,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic        br_eq,
   input  logic        br_lt,
   output logic        br_un,
   output logic        pc_sel,
   output logic        reg_wen,
   output logic        a_sel,
   output logic        b_sel,
   output logic [1:0]  data_w_sel,
   output logic        mem_rw,
   output logic [2:0]  data_r_sel,
   output logic [1:0]  wb_sel,
   output logic        illegal
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam bit RV64 = (XLEN == 64);

   typedef struct packed {
      logic       regWen;
      logic       aSel;
      logic       bSel;
      logic [1:0] dataWSel;
      logic       memRw;
      logic [2:0] dataRSel;
      logic [1:0] wbSel;
      logic       illegal;
      logic       isB;
      logic       isJump;
      logic [2:0] funct3;
   } entry_t;

   entry_t          r_mem [DEPTH];
   logic [PW-1:0]   r_wrPtr;
   logic [PW-1:0]   r_rdPtr;
   logic [CW-1:0]   r_count;

   logic [6:0] w_op;
   logic [2:0] w_f3;
   logic       w_isR, w_isIC, w_isIL, w_isS, w_isB, w_isLui, w_isAuipc, w_isJal, w_isJalr;
   logic       w_known, w_illegal;
   entry_t     w_dec;
   entry_t     w_head;
   logic       w_taken;
   logic       w_push, w_pop, w_redirect, w_write;
   logic       w_unusedBits;

   assign w_op         = instr[6:0];
   assign w_f3         = instr[14:12];
   assign w_unusedBits = ^{instr[31:15], instr[11:7]};

   assign w_isR     = (w_op == 7'b0110011);
   assign w_isIC    = (w_op == 7'b0010011);
   assign w_isIL    = (w_op == 7'b0000011);
   assign w_isS     = (w_op == 7'b0100011);
   assign w_isB     = (w_op == 7'b1100011);
   assign w_isLui   = (w_op == 7'b0110111);
   assign w_isAuipc = (w_op == 7'b0010111);
   assign w_isJal   = (w_op == 7'b1101111);
   assign w_isJalr  = (w_op == 7'b1100111);
   assign w_known   = w_isR | w_isIC | w_isIL | w_isS | w_isB | w_isLui | w_isAuipc | w_isJal | w_isJalr;

   // Doubleword and unsigned-word memory ops only exist on the 64-bit datapath.
   always_comb begin
      w_illegal = ~w_known;
      if (w_isB && (w_f3[2:1] == 2'b01))
         w_illegal = 1'b1;
      if (w_isIL && ((w_f3 == 3'b111) || (!RV64 && ((w_f3 == 3'b011) || (w_f3 == 3'b110)))))
         w_illegal = 1'b1;
      if (w_isS && (w_f3[2] || (!RV64 && (w_f3 == 3'b011))))
         w_illegal = 1'b1;
      if (w_isJalr && (w_f3 != 3'b000))
         w_illegal = 1'b1;
   end

   always_comb begin
      w_dec          = '0;
      w_dec.regWen   = ~(w_isS | w_isB | w_illegal);
      w_dec.aSel     = w_isB | w_isAuipc | w_isJal;
      w_dec.bSel     = ~w_isR;
      w_dec.memRw    = w_isS & ~w_illegal;
      w_dec.wbSel    = w_isIL ? 2'b00 : ((w_isJal | w_isJalr) ? 2'b10 : 2'b01);
      w_dec.illegal  = w_illegal;
      w_dec.isB      = w_isB;
      w_dec.isJump   = w_isJal | w_isJalr;
      w_dec.funct3   = w_f3;
      if (w_isIL && !w_illegal) begin
         case (w_f3)
            3'b000:  w_dec.dataRSel = 3'b001;
            3'b001:  w_dec.dataRSel = 3'b010;
            3'b100:  w_dec.dataRSel = 3'b011;
            3'b101:  w_dec.dataRSel = 3'b100;
            3'b110:  w_dec.dataRSel = 3'b101;
            3'b011:  w_dec.dataRSel = 3'b110;
            default: w_dec.dataRSel = 3'b000;
         endcase
      end
      if (w_isS && !w_illegal) begin
         case (w_f3)
            3'b000:  w_dec.dataWSel = 2'b01;
            3'b001:  w_dec.dataWSel = 2'b11;
            3'b011:  w_dec.dataWSel = 2'b10;
            default: w_dec.dataWSel = 2'b00;
         endcase
      end
   end

   assign w_head    = r_mem[r_rdPtr];
   assign in_ready  = (r_count < FULL);
   assign out_valid = (r_count != '0);
   assign w_taken   = w_head.funct3[2] ? (br_lt ^ w_head.funct3[0]) : (br_eq ^ w_head.funct3[0]);

   always_comb begin
      pc_sel     = 1'b0;
      br_un      = 1'b0;
      reg_wen    = 1'b0;
      a_sel      = 1'b0;
      b_sel      = 1'b0;
      data_w_sel = 2'b00;
      mem_rw     = 1'b0;
      data_r_sel = 3'b000;
      wb_sel     = 2'b00;
      illegal    = 1'b0;
      if (out_valid) begin
         pc_sel     = ~w_head.illegal & (w_head.isJump | (w_head.isB & w_taken));
         br_un      = w_head.isB & w_head.funct3[1];
         reg_wen    = w_head.regWen;
         a_sel      = w_head.aSel;
         b_sel      = w_head.bSel;
         data_w_sel = w_head.dataWSel;
         mem_rw     = w_head.memRw;
         data_r_sel = w_head.dataRSel;
         wb_sel     = w_head.wbSel;
         illegal    = w_head.illegal;
      end
   end

   assign w_push     = in_valid & in_ready;
   assign w_pop      = out_valid & out_ready;
   assign w_redirect = w_pop & pc_sel;
   assign w_write    = w_push & ~flush_in & ~w_redirect;

   always_ff @(posedge clk) begin
      if (w_write)
         r_mem[r_wrPtr] <= w_dec;
   end

   // Flush and a taken redirect both empty the FIFO and drop any same-cycle push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (flush_in || w_redirect) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop)
            r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
